// File: rtl/lrf_frame_scheduler.sv
// lrf_frame_scheduler
// Sequences the DDR frame reads that feed LRF. Every image gets a NEW pass
// (its own frame) followed by an OLD pass (the frame 2^N_FUSE_COUNT images
// back, or frame 0 near the start of the sequence). Each pass is one read
// command to the MM2S mover; completion is tracked by watching the beats LRF
// accepts on its s_axis port. After the last image, zero-data flush beats
// push the tail of the LRF pipeline out.

module lrf_frame_scheduler #(
  parameter int  PIXELS_PER_BEAT = 16,
  parameter int  IMAGE_DIM       = 512,
  parameter int  N_FUSE_COUNT    = 4,
  parameter int  PIPELINE_DELAY  = 10,
  parameter int  ADDR_W          = 32,
  parameter int  FRAME_W         = 16,
  localparam int WORDS_PER_IMAGE = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
  localparam int LEN_W           = $clog2(WORDS_PER_IMAGE + 1)
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_areset,
  // host configuration
  input  logic               cfg_start,
  input  logic [FRAME_W-1:0] cfg_num_images,
  input  logic [ADDR_W-1:0]  cfg_base_addr,
  // read command to the MM2S mover
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [ADDR_W-1:0]  cmd_addr,
  output logic [LEN_W-1:0]   cmd_len,
  output logic               cmd_old,
  // monitor taps on LRF's s_axis input
  input  logic               mon_tvalid,
  input  logic               mon_tready,
  input  logic               mon_tlast,
  // zero-data flush beats
  output logic               flush_tvalid,
  input  logic               flush_tready,
  // status
  output logic               busy,
  output logic               done,
  output logic               err_tlast
);

  // Offset between an image and the older frame it is fused with.
  localparam int unsigned OLD_OFFSET = 1 << N_FUSE_COUNT;

  // Flush counter only has to reach PIPELINE_DELAY-1.
  localparam int FLUSH_W = (PIPELINE_DELAY > 1) ? $clog2(PIPELINE_DELAY) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST =
    FLUSH_W'((PIPELINE_DELAY > 0) ? PIPELINE_DELAY - 1 : 0);

  localparam logic [LEN_W-1:0]  LAST_BEAT = LEN_W'(WORDS_PER_IMAGE - 1);
  localparam logic [ADDR_W-1:0] WORDS_A   = ADDR_W'(WORDS_PER_IMAGE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_NEW,
    S_XFER_NEW,
    S_CMD_OLD,
    S_XFER_OLD,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [FRAME_W-1:0] num_q;       // images in this run
  logic [ADDR_W-1:0]  base_q;      // word address of frame 0
  logic [FRAME_W-1:0] img_q;       // image currently being processed
  logic [LEN_W-1:0]   beat_q;      // beats seen in the current pass
  logic [FLUSH_W-1:0] flush_q;     // flush beats accepted so far

  logic               start_accept;
  logic               beat_hs;
  logic               in_xfer;
  logic               last_beat;
  logic               pass_end;
  logic               last_image;
  logic [FRAME_W:0]   img_inc_w;
  logic [FRAME_W-1:0] img_next;
  logic [FRAME_W-1:0] old_idx;

  // Word address of frame idx, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] frame_addr(input logic [ADDR_W-1:0]  base,
                                                   input logic [FRAME_W-1:0] idx);
    return base + ADDR_W'(idx) * WORDS_A;
  endfunction

  assign cmd_len = LEN_W'(WORDS_PER_IMAGE);

  // Beat tracking is only meaningful while a pass is in flight; handshakes
  // seen in any other state are deliberately ignored.
  assign beat_hs   = mon_tvalid & mon_tready;
  assign in_xfer   = (state_q == S_XFER_NEW) || (state_q == S_XFER_OLD);
  assign last_beat = (beat_q == LAST_BEAT);
  assign pass_end  = in_xfer & beat_hs & last_beat;

  // One extra bit keeps img+1 from wrapping before it is compared.
  assign img_inc_w  = {1'b0, img_q} + (FRAME_W + 1)'(1);
  assign img_next   = img_q + FRAME_W'(1);
  assign last_image = (img_inc_w == {1'b0, num_q});

  // Early images have no frame far enough back, so they fuse with frame 0.
  assign old_idx = (32'(img_q) >= OLD_OFFSET) ? img_q - FRAME_W'(OLD_OFFSET) : '0;

  // State register.
  always_ff @(posedge s_axis_aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (s_axis_areset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and state-derived handshake/status outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    state_d      = state_q;
    cmd_valid    = 1'b0;
    flush_tvalid = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    start_accept = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (cfg_start) begin
          start_accept = 1'b1;
          state_d      = (cfg_num_images == '0) ? S_DONE : S_CMD_NEW;
        end
      end

      S_CMD_NEW: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_d = S_XFER_NEW;
      end

      S_XFER_NEW: begin
        if (pass_end) state_d = S_CMD_OLD;
      end

      S_CMD_OLD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_d = S_XFER_OLD;
      end

      S_XFER_OLD: begin
        if (pass_end) begin
          if (!last_image)              state_d = S_CMD_NEW;
          else if (PIPELINE_DELAY == 0) state_d = S_DONE;
          else                          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        flush_tvalid = 1'b1;
        if (flush_tready && (flush_q == FLUSH_LAST)) state_d = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Run configuration and image index; later cfg_* changes are ignored.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      num_q  <= '0;
      base_q <= '0;
      img_q  <= '0;
    end else if (start_accept) begin
      num_q  <= cfg_num_images;
      base_q <= cfg_base_addr;
      img_q  <= '0;
    end else if ((state_q == S_XFER_OLD) && pass_end) begin
      img_q  <= img_next;
    end
  end

  // Beat counter for the pass in flight; restarts when a command is accepted.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      beat_q <= '0;
    end else if (cmd_valid && cmd_ready) begin
      beat_q <= '0;
    end else if (in_xfer && beat_hs) begin
      beat_q <= beat_q + LEN_W'(1);
    end
  end

  // Sticky tlast check: tlast must coincide exactly with the final beat.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      err_tlast <= 1'b0;
    end else if (start_accept) begin
      err_tlast <= 1'b0;
    end else if (in_xfer && beat_hs && (mon_tlast != last_beat)) begin
      err_tlast <= 1'b1;
    end
  end

  // Command register, loaded on entry to each CMD state so that address and
  // pass type are stable for the whole time cmd_valid is up.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      cmd_addr <= '0;
      cmd_old  <= 1'b0;
    end else if (start_accept) begin
      cmd_addr <= cfg_base_addr;
      cmd_old  <= 1'b0;
    end else if ((state_q == S_XFER_NEW) && pass_end) begin
      cmd_addr <= frame_addr(base_q, old_idx);
      cmd_old  <= 1'b1;
    end else if ((state_q == S_XFER_OLD) && pass_end) begin
      cmd_addr <= frame_addr(base_q, img_next);
      cmd_old  <= 1'b0;
    end
  end

  // Flush beat counter, cleared for every new run.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      flush_q <= '0;
    end else if (start_accept) begin
      flush_q <= '0;
    end else if (flush_tvalid && flush_tready) begin
      flush_q <= flush_q + FLUSH_W'(1);
    end
  end

endmodule

// File: tb/tb_lrf_frame_scheduler.sv
// tb_lrf_frame_scheduler
// Randomized bench for lrf_frame_scheduler. The bench plays the host, the
// mover (cmd_ready) and the LRF stream source (mon_*), and checks the DUT
// against a transaction-level model: the expected command list is built up
// front from the image/fusion rules, and beat, flush and done expectations
// follow from counting handshakes.

module tb_lrf_frame_scheduler;

  // Small frames keep runs short: 16x16 px at 16 px/beat = 16 beats per pass.
  localparam int PPB  = 16;
  localparam int DIM  = 16;
  localparam int NF   = 2;
  localparam int PD   = 10;
  localparam int AW   = 32;
  localparam int FW   = 16;
  localparam int W    = DIM * DIM / PPB;
  localparam int LW   = $clog2(W + 1);
  localparam int OFFS = 1 << NF;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic [FW-1:0] cfg_num_images = '0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_old;
  logic          mon_tvalid = 1'b0;
  logic          mon_tready = 1'b0;
  logic          mon_tlast = 1'b0;
  logic          flush_tvalid;
  logic          flush_tready = 1'b0;
  logic          busy;
  logic          done;
  logic          err_tlast;

  always #5 clk = ~clk;

  lrf_frame_scheduler #(
    .PIXELS_PER_BEAT(PPB),
    .IMAGE_DIM      (DIM),
    .N_FUSE_COUNT   (NF),
    .PIPELINE_DELAY (PD),
    .ADDR_W         (AW),
    .FRAME_W        (FW)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .cfg_start     (cfg_start),
    .cfg_num_images(cfg_num_images),
    .cfg_base_addr (cfg_base_addr),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_old       (cmd_old),
    .mon_tvalid    (mon_tvalid),
    .mon_tready    (mon_tready),
    .mon_tlast     (mon_tlast),
    .flush_tvalid  (flush_tvalid),
    .flush_tready  (flush_tready),
    .busy          (busy),
    .done          (done),
    .err_tlast     (err_tlast)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          old;
  } cmd_t;

  cmd_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit            run_active, pass_active, hold_pending, exp_err;
  bit            expect_cmd_now, expect_flush_now, expect_done_now, start_req;
  int            beats_sent, cmds_seen, flush_seen;
  int            run_num, ready_pct, valid_pct, inject_cmd, inject_beat;
  logic [AW-1:0] run_base;
  logic [AW-1:0] held_addr;
  logic          held_old;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    run_active       = 1'b0;
    pass_active      = 1'b0;
    hold_pending     = 1'b0;
    exp_err          = 1'b0;
    expect_cmd_now   = 1'b0;
    expect_flush_now = 1'b0;
    expect_done_now  = 1'b0;
    start_req        = 1'b0;
    beats_sent       = 0;
    cmds_seen        = 0;
    flush_seen       = 0;
    exp_q.delete();
  endtask

  // Command list for a run: image i reads frame i, then frame i-OFFS (or 0).
  task automatic build_expected(input int num, input logic [AW-1:0] base);
    cmd_t c;
    exp_q.delete();
    for (int i = 0; i < num; i++) begin
      c.addr = base + AW'(i * W);
      c.old  = 1'b0;
      exp_q.push_back(c);
      c.addr = base + AW'(((i >= OFFS) ? i - OFFS : 0) * W);
      c.old  = 1'b1;
      exp_q.push_back(c);
    end
  endtask

  // One clock: check outputs at the falling edge, drive inputs, then advance
  // the model by the handshakes that complete on the rising edge.
  task automatic cycle();
    logic          s_cmd_valid, s_flush_tvalid, s_done, s_cmd_old;
    logic [AW-1:0] s_cmd_addr;
    logic          c_hs, m_hs, f_hs, tl, s_acc, ok_f;
    cmd_t          front;

    @(negedge clk);
    s_cmd_valid    = cmd_valid;
    s_cmd_addr     = cmd_addr;
    s_cmd_old      = cmd_old;
    s_flush_tvalid = flush_tvalid;
    s_done         = done;

    check("busy", busy, run_active);
    check("done", s_done, expect_done_now);
    check("err_tlast", err_tlast, exp_err);
    check("cmd_len", cmd_len, W);
    check("cmd_flush_excl", s_cmd_valid & s_flush_tvalid, 0);
    if (pass_active) check("one_outstanding", s_cmd_valid, 0);
    if (hold_pending) begin
      check("cmd_hold", s_cmd_valid, 1);
      check("cmd_addr_stable", s_cmd_addr, held_addr);
      check("cmd_old_stable", s_cmd_old, held_old);
    end
    if (expect_cmd_now)   check("cmd_latency", s_cmd_valid, 1);
    if (expect_flush_now) check("flush_latency", s_flush_tvalid, 1);
    if (s_flush_tvalid) begin
      ok_f = run_active && !pass_active && (exp_q.size() == 0) && (flush_seen < PD);
      check("flush_order", ok_f, 1);
    end

    // Drive inputs
    s_acc          = start_req && !run_active;
    cfg_start      = start_req;
    cfg_num_images = s_acc ? FW'(run_num) : FW'($urandom);
    cfg_base_addr  = s_acc ? run_base : AW'($urandom);
    cmd_ready      = ($urandom_range(99) < ready_pct);
    flush_tready   = ($urandom_range(99) < ready_pct);
    if (pass_active) begin
      mon_tvalid = ($urandom_range(99) < valid_pct);
      mon_tready = ($urandom_range(99) < valid_pct);
      tl = (beats_sent == W - 1);
      if ((cmds_seen - 1 == inject_cmd) && (beats_sent == inject_beat)) tl = !tl;
    end else begin
      // Stray traffic outside a pass must be ignored by the DUT.
      mon_tvalid = ($urandom_range(99) < 30);
      mon_tready = ($urandom_range(99) < 50);
      tl = 1'($urandom_range(1));
    end
    mon_tlast = tl;

    c_hs = s_cmd_valid && cmd_ready;
    m_hs = pass_active && mon_tvalid && mon_tready;
    f_hs = s_flush_tvalid && flush_tready;

    if (c_hs) begin
      if (exp_q.size() == 0) begin
        check("cmd_unexpected", s_cmd_valid, 0);
      end else begin
        front = exp_q.pop_front();
        check("cmd_addr", s_cmd_addr, front.addr);
        check("cmd_old", s_cmd_old, front.old);
      end
    end

    @(posedge clk);

    hold_pending     = s_cmd_valid && !cmd_ready;
    held_addr        = s_cmd_addr;
    held_old         = s_cmd_old;
    expect_cmd_now   = 1'b0;
    expect_flush_now = 1'b0;
    expect_done_now  = 1'b0;
    if (s_done) run_active = 1'b0;

    if (s_acc) begin
      run_active  = 1'b1;
      pass_active = 1'b0;
      exp_err     = 1'b0;
      cmds_seen   = 0;
      flush_seen  = 0;
      build_expected(run_num, run_base);
      if (run_num == 0) expect_done_now = 1'b1;
      else              expect_cmd_now  = 1'b1;
    end
    if (c_hs) begin
      pass_active = 1'b1;
      beats_sent  = 0;
      cmds_seen++;
    end
    if (m_hs) begin
      if (tl != (beats_sent == W - 1)) exp_err = 1'b1;
      beats_sent++;
      if (beats_sent == W) begin
        pass_active = 1'b0;
        if (exp_q.size() > 0) expect_cmd_now   = 1'b1;
        else if (PD > 0)      expect_flush_now = 1'b1;
        else                  expect_done_now  = 1'b1;
      end
    end
    if (f_hs) begin
      flush_seen++;
      if (flush_seen == PD) expect_done_now = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    start_req = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Start a run and follow it to its done pulse (or to the stop point).
  task automatic run_seq(input int num, input logic [AW-1:0] base,
                         input int rp, input int vp,
                         input int inj_cmd, input int inj_beat,
                         input int stop_cmds, input int hold);
    run_num     = num;
    run_base    = base;
    ready_pct   = rp;
    valid_pct   = vp;
    inject_cmd  = inj_cmd;
    inject_beat = inj_beat;
    for (int k = 0; k < BUDGET; k++) begin
      start_req = (k < hold);
      cycle();
      if (!run_active) break;
      if ((stop_cmds > 0) && (cmds_seen == stop_cmds) && pass_active && (beats_sent >= 3)) begin
        start_req = 1'b0;
        return;
      end
    end
    start_req = 1'b0;
    check("run_finished", run_active, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_cmd_addr"}, cmd_addr, 0);
    check({tag, "_cmd_old"}, cmd_old, 0);
    check({tag, "_flush_tvalid"}, flush_tvalid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_tlast"}, err_tlast, 0);
  endtask

  initial begin
    int n;
    model_clear();
    ready_pct = 100;
    valid_pct = 100;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Three images, always-ready handshakes
    run_seq(3, 32'h0000_1000, 100, 100, -1, 0, 0, 1);
    idle(3);

    // Long run crossing the fusion offset, with stalls and late start held high
    run_seq(20, 32'h0002_0000, 70, 70, -1, 0, 0, 3);
    idle(3);

    // Early tlast in pass 0; the error must persist after the run
    run_seq(2, 32'h0000_4000, 80, 80, 0, 5, 0, 1);
    idle(5);

    // Zero images: done immediately, start held into the busy cycle
    run_seq(0, 32'h0000_8000, 100, 100, -1, 0, 0, 2);
    idle(4);

    // Base near the top of the address space wraps
    run_seq(2, 32'hFFFF_FFF8, 60, 60, -1, 0, 0, 1);
    idle(2);

    // Randomized runs, some with a misplaced tlast
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 7);
      run_seq(n, AW'($urandom), $urandom_range(30, 95), $urandom_range(30, 95),
              ($urandom_range(1) != 0) ? $urandom_range(0, 2 * n - 1) : -1,
              $urandom_range(0, W - 1), 0, $urandom_range(1, 3));
      idle($urandom_range(1, 4));
    end

    // Reset in the OLD pass of image 1, then a fresh run from image 0
    run_seq(3, 32'h0001_0000, 90, 90, 0, 2, 4, 1);
    @(negedge clk);
    rst          = 1'b1;
    cfg_start    = 1'b0;
    cmd_ready    = 1'b0;
    mon_tvalid   = 1'b0;
    mon_tready   = 1'b0;
    mon_tlast    = 1'b0;
    flush_tready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrun_reset");
    rst = 1'b0;
    model_clear();
    run_seq(2, 32'h0003_0000, 80, 80, -1, 0, 0, 1);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
